// File: rtl/bcd_ram_arbiter.sv
// Two-source round-robin arbiter that packs 18-bit BCD words into a shared RAM,
// tracking per-source frame offsets and flagging framing errors.
module bcd_ram_arbiter #(
    parameter int unsigned FRAME_LEN = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        sof0,
    input  logic        sof1,
    input  logic [17:0] word0,
    input  logic [17:0] word1,
    output logic        ack0,
    output logic        ack1,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [17:0] ram_data,
    output logic [1:0]  frame_done,
    output logic [1:0]  frame_err
);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    localparam logic [6:0] LastOff = 7'(FRAME_LEN - 1);

    state_e          state_q, state_d;
    logic [1:0]      ack_q, ack_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [17:0]     data_q, data_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [1:0][6:0] cnt_q, cnt_d;
    logic            last_q, last_d;

    logic        win;
    logic        win_sof;
    logic [17:0] win_word;
    logic [6:0]  win_cnt;
    logic        misalign;
    logic [6:0]  offset;

    always_comb begin
        // On a tie the source not granted last time wins
        win      = req1 & (~req0 | ~last_q);
        win_sof  = win ? sof1 : sof0;
        win_word = win ? word1 : word0;
        win_cnt  = cnt_q[win];
        // sof must coincide exactly with offset 0; otherwise realign to 0
        misalign = win_sof != (win_cnt == 7'd0);
        offset   = misalign ? 7'd0 : win_cnt;

        state_d = state_q;
        ack_d   = 2'b00;
        we_d    = 1'b0;
        done_d  = 2'b00;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d     = StWrite;
                    ack_d[win]  = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = {win, offset};
                    data_d      = win_word;
                    done_d[win] = (offset == LastOff);
                    cnt_d[win]  = (offset == LastOff) ? 7'd0 : 7'(offset + 7'd1);
                    last_d      = win;
                    if (misalign) begin
                        err_d[win] = 1'b1;
                    end
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ack_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            data_q  <= 18'd0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign ack0       = ack_q[0];
    assign ack1       = ack_q[1];
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_bcd_ram_arbiter.sv
// Randomized bench for bcd_ram_arbiter: per-source word queues drive requests and a
// frame-level reference model predicts every output on every cycle.
module tb_bcd_ram_arbiter;

    localparam int FL = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, sof0 = 1'b0, sof1 = 1'b0;
    logic [17:0] word0 = '0, word1 = '0;
    logic        ack0, ack1, ram_we;
    logic [7:0]  ram_addr;
    logic [17:0] ram_data;
    logic [1:0]  frame_done, frame_err;

    int errors = 0;
    int checks = 0;

    // Pending words per source: {sof, word}
    logic [18:0] q0[$];
    logic [18:0] q1[$];

    // Reference model state and predicted outputs
    bit          m_busy = 1'b0;
    int          m_last = 1;
    int          m_cnt[2] = '{0, 0};
    logic [1:0]  exp_ack = '0, exp_done = '0, exp_err = '0;
    logic        exp_we = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [17:0] exp_data = '0;

    bcd_ram_arbiter #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .sof0       (sof0),
        .sof1       (sof1),
        .word0      (word0),
        .word1      (word1),
        .ack0       (ack0),
        .ack1       (ack1),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] obs();
        return {ack1, ack0, ram_we, frame_done, frame_err, ram_addr, ram_data};
    endfunction

    function automatic logic [32:0] expv();
        return {exp_ack, exp_we, exp_done, exp_err, exp_addr, exp_data};
    endfunction

    // One accepted word per two cycles; offset follows the frame rules directly.
    task automatic model_edge();
        int w, off;
        bit s;
        exp_ack  = '0;
        exp_we   = 1'b0;
        exp_done = '0;
        if (rst) begin
            m_busy   = 1'b0;
            m_last   = 1;
            m_cnt    = '{0, 0};
            exp_err  = '0;
            exp_addr = '0;
            exp_data = '0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (req0 || req1) begin
            w = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
            s = (w == 1) ? sof1 : sof0;
            if (s != (m_cnt[w] == 0)) begin
                exp_err[w] = 1'b1;
                off = 0;
            end else begin
                off = m_cnt[w];
            end
            m_cnt[w]    = (off + 1) % FL;
            exp_done[w] = (off == FL - 1);
            exp_addr    = 8'(w * 128 + off);
            exp_data    = (w == 1) ? word1 : word0;
            exp_ack[w]  = 1'b1;
            exp_we      = 1'b1;
            m_last      = w;
            m_busy      = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        req0 = (q0.size() != 0);
        req1 = (q1.size() != 0);
        if (req0) {sof0, word0} = q0[0]; else sof0 = 1'b0;
        if (req1) {sof1, word1} = q1[0]; else sof1 = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        if (exp_ack[0] && q0.size() != 0) void'(q0.pop_front());
        if (exp_ack[1] && q1.size() != 0) void'(q1.pop_front());
    endtask

    task automatic push(input int src, input bit sof);
        logic [18:0] e;
        e = {sof, 18'($urandom)};
        if (src == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push(0, 1'b1);
        push(1, 1'b1);
        cycle();
        cycle();
        checks++;
        if (obs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), 33'd0);
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", obs(), expv());
        end
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int n = 0, last_c = 0;
        do_reset();
        push(0, 1'b1);
        for (int i = 1; i < FL; i++) push(0, 1'b0);
        push(0, 1'b1);
        for (int c = 0; c < 4 * FL && n < FL + 1; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL single_model c=%0d: got %h expected %h", c, obs(), expv());
            end
            if (ram_we) begin
                checks++;
                if (ram_addr !== 8'(n % FL) || frame_done !== ((n == FL - 1) ? 2'b01 : 2'b00)
                    || (n > 0 && c - last_c != 2)) begin
                    errors++;
                    $display("FAIL single_write n=%0d: addr %h done %b gap %0d expected %h %b 2",
                             n, ram_addr, frame_done, c - last_c, 8'(n % FL),
                             (n == FL - 1) ? 2'b01 : 2'b00);
                end
                last_c = c;
                n++;
            end
        end
        checks++;
        if (n != FL + 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes expected %0d", n, FL + 1);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        logic [7:0] ea;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, i == 0);
            push(1, i == 0);
        end
        for (int c = 0; c < 40 && (q0.size() != 0 || q1.size() != 0); c++) begin
            cycle();
            checks++;
            if (obs() !== expv() || (ack0 && ack1)) begin
                errors++;
                $display("FAIL contention_model c=%0d: got %h expected %h", c, obs(), expv());
            end
            if (ram_we && n < 4) begin
                ea = 8'((n % 2) * 128 + n / 2);
                checks++;
                if ({ack1, ack0} !== ((n % 2 == 1) ? 2'b10 : 2'b01) || ram_addr !== ea) begin
                    errors++;
                    $display("FAIL contention_grant n=%0d: ack %b addr %h expected addr %h",
                             n, {ack1, ack0}, ram_addr, ea);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d writes expected 4", n);
        end
    endtask

    task automatic test_misaligned();
        int n = 0;
        logic [7:0] ea[7] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h80, 8'h81};
        logic [1:0] ee;
        do_reset();
        push(1, 1'b1);
        for (int i = 0; i < 4; i++) push(1, 1'b0);
        push(1, 1'b1);
        push(1, 1'b0);
        for (int c = 0; c < 40 && n < 7; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL misalign_model c=%0d: got %h expected %h", c, obs(), expv());
            end
            if (ram_we) begin
                ee = (n >= 5) ? 2'b10 : 2'b00;
                checks++;
                if (ram_addr !== ea[n] || frame_err !== ee) begin
                    errors++;
                    $display("FAIL misalign_write n=%0d: addr %h err %b expected %h %b",
                             n, ram_addr, frame_err, ea[n], ee);
                end
                n++;
            end
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL misalign_count: got %0d writes expected 7", n);
        end
    endtask

    task automatic test_missing_sof();
        int n = 0;
        do_reset();
        push(0, 1'b1);
        for (int i = 1; i < FL; i++) push(0, 1'b0);
        push(0, 1'b0);
        for (int c = 0; c < 4 * FL && n < FL + 1; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL nosof_model c=%0d: got %h expected %h", c, obs(), expv());
            end
            if (ram_we) begin
                if (n == FL) begin
                    checks++;
                    if (ram_addr !== 8'h00 || frame_err !== 2'b01) begin
                        errors++;
                        $display("FAIL nosof_write: addr %h err %b expected 00 01",
                                 ram_addr, frame_err);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != FL + 1) begin
            errors++;
            $display("FAIL nosof_count: got %0d writes expected %0d", n, FL + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push(0, 1'b1);
        for (int i = 1; i < 60; i++) push(0, 1'b0);
        for (int c = 0; c < 200 && n < 50; c++) begin
            cycle();
            if (ram_we) n++;
        end
        q0.delete();
        push(0, 1'b1);
        push(0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (obs() !== 33'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected %h", obs(), 33'd0);
        end
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midreset_model c=%0d: got %h expected %h", c, obs(), expv());
            end
            if (ram_we) begin
                checks++;
                if (ram_addr !== 8'(n) || frame_err !== 2'b00) begin
                    errors++;
                    $display("FAIL midreset_write n=%0d: addr %h err %b expected %h 00",
                             n, ram_addr, frame_err, 8'(n));
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL midreset_count: got %0d writes expected 2", n);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if ({ram_we, ack0, ack1, frame_done} !== 5'd0 || obs() !== expv()) begin
                errors++;
                $display("FAIL idle c=%0d: got %h expected %h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        int sc[2] = '{0, 0};
        bit s;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            for (int src = 0; src < 2; src++) begin
                if (((src == 0) ? q0.size() : q1.size()) < 2 && $urandom_range(0, 3) != 0) begin
                    s = (sc[src] % FL == 0);
                    if ($urandom_range(0, 15) == 0) s = ~s;
                    push(src, s);
                    sc[src]++;
                end
            end
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                q0.delete();
                q1.delete();
                sc = '{0, 0};
            end
            cycle();
            rst = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random_model c=%0d: got %h expected %h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_misaligned();
        test_missing_sof();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_ram_arbiter.md
BCD_RAM_ARBITER -- requirements
Module: bcd_ram_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 100, number of 18-bit words per frame per source; legal range 2..128.
REQ-002 clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0, req1  input  1 each  source word request; held high until the matching ack.
REQ-005 sof0, sof1  input  1 each  start-of-frame flag qualifying the presented word.
REQ-006 word0, word1  input  18 each  presented word {parity, flag, data[15:0]}.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: the word was accepted.
REQ-008 ram_we  output  1  one-cycle RAM write strobe.
REQ-009 ram_addr  output  8  RAM address, {source index, offset[6:0]}.
REQ-010 ram_data  output  18  RAM write data.
REQ-011 frame_done  output  2  per-source one-cycle pulse on the last word of a frame.
REQ-012 frame_err  output  2  per-source sticky framing error flag.

Function
REQ-013 FSM states: IDLE (sample requests) and WRITE (perform the write); every WRITE returns to IDLE, giving at most one word per 2 cycles.
REQ-014 In IDLE with at least one req high, the FSM shall move to WRITE at the next edge; with no req high it stays in IDLE and all strobes are 0.
REQ-015 Arbitration: single req wins; with both high, the source not granted last wins (round robin); last-grant register resets to 1, so source 0 wins the first tie.
REQ-016 On the IDLE->WRITE edge the block shall register ram_data = winner's word and ram_addr = {winner, cnt[winner]}, and assert ram_we and ack[winner] for exactly the WRITE cycle.
REQ-017 Requests are not sampled during WRITE; a source shall drop req or present its next word in the cycle after ack.
REQ-018 Per-source 7-bit offset counter cnt: on each accepted word it increments; the word at offset FRAME_LEN-1 wraps cnt to 0.
REQ-019 frame_done[src] shall be high in the same cycle as ram_we of the word written at offset FRAME_LEN-1.
REQ-020 sof on a word accepted with cnt != 0: set frame_err[src], write the word at offset 0, and set cnt to 1 (realign).
REQ-021 sof=0 on a word accepted with cnt == 0: set frame_err[src]; the word is still written at offset 0 and cnt becomes 1.
REQ-022 frame_err bits are sticky and are cleared only by rst.
REQ-023 Source 0 addresses only 0x00..0x7F; source 1 addresses only 0x80..0xFF; offsets >= FRAME_LEN are never written.
REQ-024 ram_addr and ram_data hold their last value outside WRITE; only ram_we qualifies them.

Reset
REQ-025 With rst high at an edge: state=IDLE, ack=0, ram_we=0, frame_done=0, frame_err=0, ram_addr=0, ram_data=0, cnt0=cnt1=0, last-grant=1.
REQ-026 rst overrides all other inputs; a write whose WRITE cycle coincides with rst high still shows ram_we=1 that cycle, but its count update is discarded.
REQ-027 After rst deasserts, the first request is sampled in the first cycle with rst low.

Verification
REQ-028 Single source: req0 held with sof0=1 on word 0, then 99 words -> 100 writes at addr 0x00..0x63, one per 2 cycles; frame_done[0] pulses with the write at 0x63; next word goes to 0x00.
REQ-029 Contention: req0 and req1 high from reset -> grants alternate 0,1,0,1; writes at 0x00, 0x80, 0x01, 0x81; ack pulses never overlap.
REQ-030 Misaligned sof: source 1 sends 5 words, then a word with sof1=1 -> frame_err[1]=1, that word written at 0x80, next word at 0x81; frame_err[0] stays 0.
REQ-031 Missing sof: source 0 completes a frame, then sends the next word with sof0=0 -> frame_err[0]=1 and the word is written at 0x00.
REQ-032 Reset mid-frame: assert rst after 50 source-0 words for 1 cycle -> all outputs 0 next cycle; the next sof0 word is written at 0x00 with frame_err[0]=0.
REQ-033 Idle: no req for 20 cycles -> ram_we, ack0, ack1 and frame_done stay 0 throughout.
